// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM for a subtraction-based GCD datapath.
// The FSM loads both operands, repeatedly compares them and subtracts the smaller
// from the larger until one operand is zero or both are equal. It then holds the
// result valid until start is released.
// Optional feature: define GCD_TIMEOUT_EN to abort a run once iter_cnt reaches
// MAX_ITER. The abort raises err. Without the macro, err is tied low and MAX_ITER
// is unused.
module gcd_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_zero,
  input  logic             b_zero,
  input  logic             eq,
  input  logic             lt,
  output logic             a_sel,
  output logic             b_sel,
  output logic             a_ld,
  output logic             b_ld,
  output logic             out_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CMP   = 3'd2,
    S_SUB_A = 3'd3,
    S_SUB_B = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             a_sel_q, a_sel_d;
  logic             b_sel_q, b_sel_d;
  logic             a_ld_q, a_ld_d;
  logic             b_ld_q, b_ld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             out_sel_q, out_sel_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;

`ifdef GCD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);
  logic err_q, err_d;
`else
  logic unused_max_iter;
  assign unused_max_iter = |MAX_ITER;
`endif

  // Iteration counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, counter and result-select logic.
  always_comb begin
    state_d    = state_q;
    out_sel_d  = out_sel_q;
    iter_cnt_d = iter_cnt_q;
`ifdef GCD_TIMEOUT_EN
    err_d      = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        iter_cnt_d = '0;
`ifdef GCD_TIMEOUT_EN
        err_d      = 1'b0;
`endif
        state_d    = S_CMP;
      end
      S_CMP: begin
        // Flag priority: a_zero, then b_zero, then eq, then lt.
        if (a_zero) begin
          out_sel_d = 1'b1;
          state_d   = S_DONE;
        end else if (b_zero) begin
          out_sel_d = 1'b0;
          state_d   = S_DONE;
        end else if (eq) begin
          out_sel_d = 1'b0;
          state_d   = S_DONE;
        end else begin
`ifdef GCD_TIMEOUT_EN
          if (iter_cnt_q == MAX_CNT) begin
            err_d     = 1'b1;
            out_sel_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            state_d = lt ? S_SUB_B : S_SUB_A;
          end
`else
          state_d = lt ? S_SUB_B : S_SUB_A;
`endif
        end
      end
      S_SUB_A, S_SUB_B: begin
        iter_cnt_d = sat_inc(iter_cnt_q);
        state_d    = S_CMP;
      end
      S_DONE: begin
        // Four-phase handshake: the result is held until start is released.
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the upcoming state, so the registered strobes track state_q.
  always_comb begin
    a_sel_d = (state_d == S_SUB_A);
    b_sel_d = (state_d == S_SUB_B);
    a_ld_d  = (state_d == S_LOAD) || (state_d == S_SUB_A);
    b_ld_d  = (state_d == S_LOAD) || (state_d == S_SUB_B);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d == S_LOAD) || (state_d == S_CMP) ||
              (state_d == S_SUB_A) || (state_d == S_SUB_B);
  end

  // State and registered outputs; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_sel_q    <= 1'b0;
      b_sel_q    <= 1'b0;
      a_ld_q     <= 1'b0;
      b_ld_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_sel_q  <= 1'b0;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      a_ld_q     <= a_ld_d;
      b_ld_q     <= b_ld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_sel_q  <= out_sel_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

`ifdef GCD_TIMEOUT_EN
  // Timeout flag, sticky until the next operand load or reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign a_sel    = a_sel_q;
  assign b_sel    = b_sel_q;
  assign a_ld     = a_ld_q;
  assign b_ld     = b_ld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_sel  = out_sel_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Testbench for gcd_ctrl. A behavioural 32-bit A/B datapath supplies the flags.
// Vectors come from a table, expected results flow through a scoreboard queue,
// and reset and handshake corners are exercised as hand-written sequences.
module tb_gcd_ctrl;
  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 4;

  logic             clk = 1'b0;
  logic             rst, start;
  logic             a_zero, b_zero, eq, lt;
  logic             a_sel, b_sel, a_ld, b_ld, out_sel, busy, done, err;
  logic [CNT_W-1:0] iter_cnt;
  logic [31:0]      ext_a = '0, ext_b = '0;
  logic [31:0]      reg_a = '0, reg_b = '0;

  gcd_ctrl #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_zero(a_zero), .b_zero(b_zero), .eq(eq), .lt(lt),
    .a_sel(a_sel), .b_sel(b_sel), .a_ld(a_ld), .b_ld(b_ld),
    .out_sel(out_sel), .busy(busy), .done(done), .err(err),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural datapath driven by the controller strobes.
  always @(posedge clk) begin
    if (a_ld) reg_a <= a_sel ? reg_a - reg_b : ext_a;
    if (b_ld) reg_b <= b_sel ? reg_b - reg_a : ext_b;
  end
  assign a_zero = (reg_a == 32'd0);
  assign b_zero = (reg_b == 32'd0);
  assign eq     = (reg_a == reg_b);
  assign lt     = (reg_a < reg_b);

  typedef struct {
    logic [31:0] a, b, res;
    logic        os;
    int          iter;
    logic        err;
    int          n_a, n_b;
    logic        first_b;
    int          hold;
    logic        glitch;
  } vec_t;

  typedef struct {
    logic        os;
    int          iter;
    logic        err;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [31:0] a, b, res, input logic os,
                              input int iter, input logic e, input int na, nb,
                              input logic fb, input int hold, input logic gl);
    vec_t v;
    v.a = a; v.b = b; v.res = res; v.os = os; v.iter = iter; v.err = e;
    v.n_a = na; v.n_b = nb; v.first_b = fb; v.hold = hold; v.glitch = gl;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " a_sel"}, a_sel, 0);
    chk({tag, " b_sel"}, b_sel, 0);
    chk({tag, " a_ld"},  a_ld,  0);
    chk({tag, " b_ld"},  b_ld,  0);
    chk({tag, " busy"},  busy,  0);
    chk({tag, " done"},  done,  0);
  endtask

  task automatic run(input vec_t v, input string tag);
    exp_t e;
    int   cyc, na, nb;
    bit   got, seen, first_b, busy_bad;
    @(negedge clk);
    ext_a = v.a; ext_b = v.b; start = 1'b1;
    e.os = v.os; e.iter = v.iter; e.err = v.err; e.res = v.res;
    sb.push_back(e);
    @(posedge clk);  // IDLE samples start here
    cyc = 0; got = 0; seen = 0; first_b = 0; busy_bad = 0; na = 0; nb = 0;
    while (!got && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (v.glitch) start = (cyc == 3);
      if (a_ld && a_sel) begin na++; if (!seen) begin seen = 1; first_b = 0; end end
      if (b_ld && b_sel) begin nb++; if (!seen) begin seen = 1; first_b = 1; end end
      if (done) got = 1;
      else if (!busy) busy_bad = 1;
    end
    chk({tag, " done_seen"}, got, 1);
    if (got) begin
      chk({tag, " latency"}, cyc, 2 + 2 * v.iter);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, " out_sel"},  out_sel, e.os);
        chk({tag, " iter_cnt"}, iter_cnt, e.iter);
        chk({tag, " err"},      err, e.err);
        chk({tag, " result"},   out_sel ? reg_b : reg_a, e.res);
      end
      chk({tag, " busy_at_done"}, busy, 0);
      chk({tag, " busy_gap"}, busy_bad, 0);
      chk({tag, " n_sub_a"}, na, v.n_a);
      chk({tag, " n_sub_b"}, nb, v.n_b);
      if (seen) chk({tag, " first_sub"}, first_b, v.first_b);
      for (int k = 0; k < v.hold; k++) begin
        @(posedge clk); #1;
        chk({tag, " done_hold"}, done, 1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs({tag, " back_idle"});
  endtask

  initial begin
    int  cyc;
    bit  hit;
    vecs[0] = mk(12,   8,  4, 0,  2, 0, 1,  1, 0, 5, 0);
    vecs[1] = mk(0,    7,  7, 1,  0, 0, 0,  0, 0, 0, 0);
    vecs[2] = mk(9,    0,  9, 0,  0, 0, 0,  0, 0, 0, 0);
    vecs[3] = mk(21,   6,  3, 0,  4, 0, 3,  1, 0, 0, 1);
    vecs[4] = mk(15,  15, 15, 0,  0, 0, 0,  0, 0, 2, 0);
    vecs[5] = mk(7,    3,  1, 0,  4, 0, 2,  2, 0, 0, 0);
`ifdef GCD_TIMEOUT_EN
    vecs[6] = mk(1,  100,  1, 0,  4, 1, 0,  4, 1, 0, 0);
`else
    vecs[6] = mk(1,  100,  1, 0, 99, 0, 0, 99, 1, 0, 0);
`endif
    vecs[7] = mk(0,    0,  0, 1,  0, 0, 0,  0, 0, 0, 0);

    // Reset with start held high: reset must win.
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset out_sel", out_sel, 0);
    chk("reset iter_cnt", iter_cnt, 0);
    chk("reset err", err, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("post_reset");

    for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset during SUB_B of a 1,100 run; out_sel is 1 from the previous run.
    @(negedge clk);
    ext_a = 32'd1; ext_b = 32'd100; start = 1'b1;
    cyc = 0; hit = 0;
    while (!hit && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (b_ld && b_sel && iter_cnt >= 3) hit = 1;
    end
    chk("midrun reached_sub_b", hit, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("midrun_reset");
    chk("midrun_reset out_sel", out_sel, 0);
    chk("midrun_reset iter_cnt", iter_cnt, 0);
    chk("midrun_reset err", err, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("midrun_after");

    run(vecs[0], "rerun12_8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 Parameter CNT_W, 16: width of the iteration counter.
REQ-002 Parameter MAX_ITER, 1000: subtraction limit; used only when GCD_TIMEOUT_EN is defined.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request; the operands are valid at the datapath inputs while start is high.
- a_zero  in  1  datapath flag: A register == 0.
- b_zero  in  1  datapath flag: B register == 0.
- eq  in  1  datapath flag: A == B.
- lt  in  1  datapath flag: A < B (unsigned 32-bit).
- a_sel  out  1  A-input mux select: 0 = external operand, 1 = A-B result.
- b_sel  out  1  B-input mux select: 0 = external operand, 1 = B-A result.
- a_ld  out  1  A register load enable.
- b_ld  out  1  B register load enable.
- out_sel  out  1  result mux select: 0 = A, 1 = B.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  result valid.
- err  out  1  timeout abort flag.
- iter_cnt  out  CNT_W  number of subtractions in the current or last run.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, LOAD, CMP, SUB_A, SUB_B, DONE.
REQ-005 a_sel, b_sel, a_ld, b_ld, busy and done SHALL be decoded from the state register only (Moore outputs).
REQ-006 IDLE: all strobes are 0; start=1 moves to LOAD.
REQ-007 LOAD: a_sel=0, b_sel=0, a_ld=1, b_ld=1 for one cycle; iter_cnt cleared to 0; err cleared to 0; next state is CMP.
REQ-008 CMP evaluates the flags in priority order a_zero > b_zero > eq > lt:
- a_zero: out_sel<=1, go to DONE.
- b_zero: out_sel<=0, go to DONE.
- eq: out_sel<=0, go to DONE.
- lt: go to SUB_B.
- otherwise: go to SUB_A.
- No strobes are asserted in CMP.
REQ-009 SUB_A: a_sel=1, a_ld=1 for one cycle; iter_cnt increments, saturating at all-ones; next state is CMP.
REQ-010 SUB_B: b_sel=1, b_ld=1 for one cycle; iter_cnt increments, saturating at all-ones; next state is CMP.
REQ-011 out_sel is a register written only on the CMP-to-DONE transition; it holds its value until the next CMP exit or reset.
REQ-012 DONE: done=1 and held while start=1 (4-phase handshake); start=0 moves to IDLE on the next edge.
REQ-013 start asserted in any state other than IDLE SHALL be ignored.
REQ-014 done SHALL rise exactly 2+2N cycles after the edge that samples start in IDLE, where N = number of subtractions.
REQ-015 Both operands zero: the a_zero branch is taken, out_sel=1, and the result is 0.

Reset
REQ-016 rst=1 at a rising edge SHALL force IDLE and set out_sel=0, iter_cnt=0, err=0 in any state, including mid-subtraction.
REQ-017 While in reset and on the first cycle after it, all strobes, busy and done SHALL be 0.
REQ-018 rst SHALL take priority over start.

Configuration
REQ-019 With GCD_TIMEOUT_EN defined, CMP SHALL go to DONE with err=1 and out_sel=0 when it would enter SUB_A or SUB_B and iter_cnt == MAX_ITER; err holds until the next LOAD or reset.
REQ-020 Without GCD_TIMEOUT_EN, err SHALL be tied to 0, MAX_ITER is unused, and the FSM runs until a CMP exit.

Verification
REQ-021 The bench SHALL drive the flag inputs from a behavioural 32-bit A/B datapath model and cover these scenarios:
- Operands 12,8, start held high: done rises 6 cycles after start is sampled; the sequence is SUB_A then SUB_B; iter_cnt=2; out_sel=0; the A register reads 4.
- Operands 0,7: done 2 cycles after start is sampled; out_sel=1; iter_cnt=0; result 7.
- Operands 9,0: done after 2 cycles; out_sel=0; result 9.
- Handshake: start held 5 cycles after done, so done stays high; start dropped, so IDLE the next cycle with done=0. A start pulse while busy has no effect on the state sequence.
- rst asserted in SUB_B of a 1,100 run: next cycle IDLE, all outputs 0, iter_cnt=0. A fresh 12,8 run afterwards reproduces the first scenario.
- Operands 1,100 with MAX_ITER=4:
  - With GCD_TIMEOUT_EN: done with err=1 and iter_cnt=4.
  - Without it: done with err=0, iter_cnt=99, out_sel=0, result 1.
